skolem_exhaustive_checker: RTL

- Sequential controller that exhaustively validates a combinational Skolem-function netlist (N_IN inputs, 1 output) against a golden combinational oracle for the same invertibility condition (e.g. bvsgt/bvlshr).
- Sweeps every input vector, drives it to both blocks in parallel, waits SETTLE cycles, then compares the two outputs.
- Counts mismatches and captures the first counterexample.
- Sits in the Skolem-function regression harness, one instance per synthesized Skolem module.

---
 rtl/skolem_exhaustive_checker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/skolem_exhaustive_checker.sv
// rtl/skolem_exhaustive_checker.sv - exhaustive sweep comparing a Skolem netlist against a golden oracle
module skolem_exhaustive_checker #(
    parameter int N_IN   = 8,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            stop_on_fail,
    output logic [N_IN-1:0] vec_out,
    input  logic            skolem_in,
    input  logic            golden_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic            cex_valid,
    output logic [N_IN-1:0] cex_vec,
    output logic            cex_skolem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Vector counter carries one extra bit so the last-vector test is unambiguous.
    localparam logic [N_IN:0] LAST_VEC   = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0] FULL_COUNT = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN:0] VEC_ONE    = {{N_IN{1'b0}}, 1'b1};
    localparam logic [3:0]    SETTLE_MAX = 4'(SETTLE);

    state_t        state;
    state_t        state_next;
    logic [N_IN:0] vec;
    logic [3:0]    settle_cnt;
    logic          sof_latched;
    logic          sample;
    logic          mismatch;
    logic          finish;

    assign vec_out = vec[N_IN-1:0];
    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign pass    = done && (fail_count == '0);

    // Sample edge for the current vector; an abort on the same edge suppresses it.
    always_comb begin
        sample   = (state == RUN) && !abort && (settle_cnt == SETTLE_MAX);
        mismatch = skolem_in ^ golden_in;
        finish   = (vec == LAST_VEC) || (mismatch && sof_latched);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only from IDLE/DONE, abort beats everything in RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (sample && finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sweep datapath: vector stepping, settle counting, mismatch counting and first-cex capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec         <= '0;
            settle_cnt  <= '0;
            sof_latched <= 1'b0;
            fail_count  <= '0;
            cex_valid   <= 1'b0;
            cex_vec     <= '0;
            cex_skolem  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec         <= '0;
                        settle_cnt  <= '0;
                        sof_latched <= stop_on_fail;
                        fail_count  <= '0;
                        cex_valid   <= 1'b0;
                        cex_vec     <= '0;
                        cex_skolem  <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        if (mismatch) begin
                            if (fail_count != FULL_COUNT) begin
                                fail_count <= fail_count + VEC_ONE;
                            end
                            if (!cex_valid) begin
                                cex_valid  <= 1'b1;
                                cex_vec    <= vec[N_IN-1:0];
                                cex_skolem <= skolem_in;
                            end
                        end
                        // Hold the final vector in DONE rather than stepping past it.
                        if (!finish) begin
                            vec        <= vec + VEC_ONE;
                            settle_cnt <= '0;
                        end
                    end else if (!abort) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
